// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding RV32I load/store unit in front of a 1 KB
//               byte-addressed memory. A request accepted in IDLE spends one
//               cycle in ACCESS, where the write strobe is driven or the read
//               word is captured. It then spends one cycle in RESP, where Done
//               pulses with Err and LoadData.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk          in   1   rising-edge clock
//   Rst          in   1   synchronous active-high reset
//   Req          in   1   core request strobe (sampled only in IDLE)
//   IsStore      in   1   1 = store, 0 = load
//   Funct3       in   3   RV32I width/sign code
//   Addr         in  32   byte address
//   StoreData    in  32   store data, bits [7:0] = lowest byte
//   Ready        out  1   idle, can accept Req
//   Done         out  1   one-cycle completion pulse
//   Err          out  1   fault flag, valid with Done, held until next Done
//   LoadData     out 32   extended load result, valid with Done
//   Mem_Din      out 32   memory write data
//   Mem_WR_Addr  out 32   memory write byte address
//   Mem_RD_Addr  out 32   memory read byte address (word aligned)
//   Mem_WE       out  2   00 none, 01 byte, 10 half, 11 word
//   Mem_Dout     in  32   combinational read data from Mem_RD_Addr
// ============================================================================
module load_store_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        IsStore,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Ready,
    output logic        Done,
    output logic        Err,
    output logic [31:0] LoadData,
    output logic [31:0] Mem_Din,
    output logic [31:0] Mem_WR_Addr,
    output logic [31:0] Mem_RD_Addr,
    output logic [1:0]  Mem_WE,
    input  logic [31:0] Mem_Dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_BYTE = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;

    state_t      state_q;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        err_pend_q;   // fault decided at accept, published with Done
    logic        err_q;
    logic        done_q;
    logic [31:0] load_data_q;
    logic [1:0]  we_q;

    // ------------------------------------------------------------------------
    // Fault and write-strobe decode on the incoming request. Evaluated every
    // cycle but only captured at the accepting edge.
    // ------------------------------------------------------------------------
    logic        bad_code_d;
    logic        misalign_d;
    logic        out_of_range_d;
    logic        err_d;
    logic [1:0]  we_d;

    always_comb begin
        bad_code_d     = 1'b0;
        misalign_d     = 1'b0;
        out_of_range_d = |Addr[31:10];
        we_d           = WE_NONE;

        if (IsStore) begin
            bad_code_d = Funct3[2] | (Funct3 == 3'b011);
        end else begin
            bad_code_d = (Funct3 == 3'b011) | (Funct3 == 3'b110) |
                         (Funct3 == 3'b111);
        end

        // Funct3[1:0] encodes the access size for every legal code.
        if (Funct3[1:0] == 2'b01) begin
            misalign_d = Addr[0];
        end else if (Funct3[1:0] == 2'b10) begin
            misalign_d = |Addr[1:0];
        end

        err_d = bad_code_d | misalign_d | out_of_range_d;

        if (IsStore && !err_d) begin
            case (Funct3[1:0])
                2'b00:   we_d = WE_BYTE;
                2'b01:   we_d = WE_HALF;
                2'b10:   we_d = WE_WORD;
                default: we_d = WE_NONE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Load lane selection and extension from the latched request. The memory
    // always returns the aligned word, so lanes come from the low address bits.
    // ------------------------------------------------------------------------
    logic [31:0] lane_shift_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_data_d;

    always_comb begin
        lane_shift_d = Mem_Dout >> {addr_q[1:0], 3'b000};
        byte_d       = lane_shift_d[7:0];
        half_d       = addr_q[1] ? Mem_Dout[31:16] : Mem_Dout[15:0];
        load_data_d  = 32'd0;

        if (!store_q && !err_pend_q) begin
            case (funct3_q)
                3'b000:  load_data_d = {{24{byte_d[7]}}, byte_d};
                3'b001:  load_data_d = {{16{half_d[15]}}, half_d};
                3'b010:  load_data_d = Mem_Dout;
                3'b100:  load_data_d = {24'd0, byte_d};
                3'b101:  load_data_d = {16'd0, half_d};
                default: load_data_d = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Controller and registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            err_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            load_data_q <= 32'd0;
            we_q        <= WE_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (Req) begin
                        store_q    <= IsStore;
                        funct3_q   <= Funct3;
                        addr_q     <= Addr;
                        data_q     <= StoreData;
                        err_pend_q <= err_d;
                        // Strobe is live for exactly the ACCESS cycle.
                        we_q       <= we_d;
                        state_q    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    we_q        <= WE_NONE;
                    done_q      <= 1'b1;
                    err_q       <= err_pend_q;
                    load_data_q <= load_data_d;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    we_q    <= WE_NONE;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Ready       = (state_q == S_IDLE);
    assign Done        = done_q;
    assign Err         = err_q;
    assign LoadData    = load_data_q;
    assign Mem_WE      = we_q;
    assign Mem_Din     = data_q;
    assign Mem_WR_Addr = addr_q;
    assign Mem_RD_Addr = {addr_q[31:2], 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Provides a 1 KB
//               byte memory and a reference model of the RV32I access rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        Clk;
    logic        Rst;
    logic        Req;
    logic        IsStore;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Ready;
    logic        Done;
    logic        Err;
    logic [31:0] LoadData;
    logic [31:0] Mem_Din;
    logic [31:0] Mem_WR_Addr;
    logic [31:0] Mem_RD_Addr;
    logic [1:0]  Mem_WE;
    logic [31:0] Mem_Dout;

    logic        init_en;
    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];

    int n_cmp;
    int n_mis;

    load_store_unit dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Req         (Req),
        .IsStore     (IsStore),
        .Funct3      (Funct3),
        .Addr        (Addr),
        .StoreData   (StoreData),
        .Ready       (Ready),
        .Done        (Done),
        .Err         (Err),
        .LoadData    (LoadData),
        .Mem_Din     (Mem_Din),
        .Mem_WR_Addr (Mem_WR_Addr),
        .Mem_RD_Addr (Mem_RD_Addr),
        .Mem_WE      (Mem_WE),
        .Mem_Dout    (Mem_Dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory environment: combinational little-endian read, write at the edge.
    always_comb begin
        Mem_Dout = {mem[{Mem_RD_Addr[9:2], 2'd3}], mem[{Mem_RD_Addr[9:2], 2'd2}],
                    mem[{Mem_RD_Addr[9:2], 2'd1}], mem[{Mem_RD_Addr[9:2], 2'd0}]};
    end

    always @(posedge Clk) begin
        if (init_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'((i * 7 + 3) & 255);
        end else if (Mem_WE != 2'b00) begin
            mem[Mem_WR_Addr[9:0]] <= Mem_Din[7:0];
            if (Mem_WE != 2'b01) mem[Mem_WR_Addr[9:0] + 10'd1] <= Mem_Din[15:8];
            if (Mem_WE == 2'b11) begin
                mem[Mem_WR_Addr[9:0] + 10'd2] <= Mem_Din[23:16];
                mem[Mem_WR_Addr[9:0] + 10'd3] <= Mem_Din[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input bit st, input bit [2:0] f);
        if (st) return (f <= 3'd2) ? (1 << f) : 0;
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_err(input bit st, input bit [2:0] f, input bit [31:0] a);
        int sz;
        sz = acc_size(st, f);
        if (sz == 0) return 1'b1;
        if ((a % sz) != 0) return 1'b1;
        return a >= 32'd1024;
    endfunction

    function automatic bit [31:0] model_load(input bit [2:0] f, input bit [31:0] a);
        int sz;
        bit [31:0] v;
        sz = acc_size(1'b0, f);
        v = 0;
        for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[int'(a[9:0]) + k]) << (8 * k));
        if (!f[2] && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 1);
        return v;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!Ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!Ready) chk("ready_timeout", 32'(Ready), 32'd1);
    endtask

    // Issue one access from an IDLE negedge; returns the observed LoadData.
    task automatic do_op(input bit st, input bit [2:0] f, input bit [31:0] a,
                         input bit [31:0] d, output logic [31:0] ld, output logic er);
        bit        e;
        bit [31:0] exp_ld;
        bit [1:0]  exp_we;
        wait_ready();
        e      = model_err(st, f, a);
        exp_ld = (st || e) ? 32'd0 : model_load(f, a);
        exp_we = (st && !e) ? 2'(f + 3'd1) : 2'b00;
        Req = 1'b1; IsStore = st; Funct3 = f; Addr = a; StoreData = d;
        @(posedge Clk);
        #1;
        Req = 1'b0; IsStore = 1'($urandom); Funct3 = 3'($urandom);
        Addr = $urandom; StoreData = $urandom;
        @(negedge Clk);  // ACCESS
        chk("acc_ready", 32'(Ready), 32'd0);
        chk("acc_done", 32'(Done), 32'd0);
        chk("acc_we", 32'(Mem_WE), 32'(exp_we));
        chk("wr_addr", Mem_WR_Addr, a);
        chk("rd_addr", Mem_RD_Addr, a & 32'hFFFF_FFFC);
        chk("din", Mem_Din, d);
        @(negedge Clk);  // RESP
        chk("resp_done", 32'(Done), 32'd1);
        chk("resp_err", 32'(Err), 32'(e));
        chk("resp_ld", LoadData, exp_ld);
        chk("resp_we", 32'(Mem_WE), 32'd0);
        ld = LoadData;
        er = Err;
        if (st && !e) begin
            for (int k = 0; k < acc_size(1'b1, f); k++)
                ref_mem[int'(a[9:0]) + k] = d[8 * k +: 8];
        end
        @(negedge Clk);  // back in IDLE
        chk("idle_ready", 32'(Ready), 32'd1);
        chk("idle_done", 32'(Done), 32'd0);
        chk("hold_err", 32'(Err), 32'(e));
        chk("hold_wr_addr", Mem_WR_Addr, a);
    endtask

    initial begin
        logic [31:0] ld;
        logic        er;
        int          nd;
        int          nbad;
        bit [2:0]    rf;
        bit [31:0]   ra;
        n_cmp = 0; n_mis = 0;
        Rst = 1'b1; init_en = 1'b1; Req = 1'b0; IsStore = 1'b0; Funct3 = 3'd0;
        Addr = 32'd0; StoreData = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'((i * 7 + 3) & 255);
        repeat (3) @(negedge Clk);
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_ld", LoadData, 32'd0);
        chk("rst_we", 32'(Mem_WE), 32'd0);
        chk("rst_din", Mem_Din, 32'd0);
        chk("rst_wr", Mem_WR_Addr, 32'd0);
        chk("rst_rd", Mem_RD_Addr, 32'd0);
        Rst = 1'b0; init_en = 1'b0;
        @(negedge Clk);

        // SW then LW
        do_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, ld, er);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_ld", ld, 32'd0);
        do_op(1'b0, 3'd2, 32'h10, 32'h0, ld, er);
        chk("lw_val", ld, 32'hDEADBEEF);

        // Byte/half loads over 80 7F 01 FF
        do_op(1'b1, 3'd2, 32'h20, 32'hFF017F80, ld, er);
        do_op(1'b0, 3'd0, 32'h20, 32'h0, ld, er);  chk("lb20", ld, 32'hFFFFFF80);
        do_op(1'b0, 3'd4, 32'h20, 32'h0, ld, er);  chk("lbu20", ld, 32'h00000080);
        do_op(1'b0, 3'd0, 32'h23, 32'h0, ld, er);  chk("lb23", ld, 32'hFFFFFFFF);
        do_op(1'b0, 3'd1, 32'h22, 32'h0, ld, er);  chk("lh22", ld, 32'hFFFFFF01);
        do_op(1'b0, 3'd5, 32'h22, 32'h0, ld, er);  chk("lhu22", ld, 32'h0000FF01);

        // Misalignment, range, encoding
        do_op(1'b1, 3'd1, 32'h31, 32'h12345678, ld, er); chk("sh31_err", 32'(er), 32'd1);
        do_op(1'b0, 3'd2, 32'h32, 32'h0, ld, er);
        chk("lw32_err", 32'(er), 32'd1); chk("lw32_ld", ld, 32'd0);
        do_op(1'b0, 3'd2, 32'h400, 32'h0, ld, er); chk("lw400_err", 32'(er), 32'd1);
        do_op(1'b0, 3'd0, 32'h3FF, 32'h0, ld, er); chk("lb3ff_err", 32'(er), 32'd0);
        do_op(1'b1, 3'd4, 32'h40, 32'hCAFEF00D, ld, er); chk("st100_err", 32'(er), 32'd1);

        // Req held high: accept every third cycle
        wait_ready();
        Req = 1'b1; IsStore = 1'b0; Funct3 = 3'd2; Addr = 32'h10;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            chk("hold_done", 32'(Done), 32'((i % 3) == 2));
            chk("hold_ready", 32'(Ready), 32'((i % 3) == 0));
            if (i == 12) Req = 1'b0;
        end

        // Req pulsed during ACCESS and held through the Done cycle: ignored
        wait_ready();
        Req = 1'b1; IsStore = 1'b0; Funct3 = 3'd2; Addr = 32'h10;
        @(posedge Clk); #1; Req = 1'b0;
        @(negedge Clk);
        Req = 1'b1; Funct3 = 3'd0; Addr = 32'h20;
        @(negedge Clk);
        chk("pulse_done", 32'(Done), 32'd1);
        @(negedge Clk);
        chk("pulse_ready1", 32'(Ready), 32'd1);
        Req = 1'b0;
        @(negedge Clk);
        chk("pulse_ready2", 32'(Ready), 32'd1);
        chk("pulse_nodone", 32'(Done), 32'd0);

        // Reset during ACCESS of an SB
        Req = 1'b1; IsStore = 1'b1; Funct3 = 3'd0; Addr = 32'h44; StoreData = 32'hAB;
        @(posedge Clk); #1; Req = 1'b0;
        @(negedge Clk);
        chk("rmid_we", 32'(Mem_WE), 32'd1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("rmid_ready", 32'(Ready), 32'd1);
        chk("rmid_done", 32'(Done), 32'd0);
        chk("rmid_we0", 32'(Mem_WE), 32'd0);
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (Done) nd++;
        end
        chk("rmid_nodone", 32'(nd), 32'd0);
        ref_mem[32'h44] = mem[32'h44];  // that write is allowed to have landed

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            rf = 3'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) ra = ra & ~32'(acc_size(1'b0, rf) - 1);
            do_op(1'($urandom), rf, ra, $urandom, ld, er);
        end

        nbad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_final", 32'(nbad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
